// File: rtl/interleaver_ctrl_pkg.sv
// Shared definitions for the 802.11a block interleaver controller:
// RATE codes, the N_CBPS/N_BPSC table, FSM state encoding and small helpers.
package interleaver_ctrl_pkg;

    localparam int ADDR_W   = 9;
    localparam int MAX_CBPS = 288;

    // 802.11a RATE field codes
    localparam logic [3:0] RATE_6  = 4'b1101;
    localparam logic [3:0] RATE_9  = 4'b1111;
    localparam logic [3:0] RATE_12 = 4'b0101;
    localparam logic [3:0] RATE_18 = 4'b0111;
    localparam logic [3:0] RATE_24 = 4'b1001;
    localparam logic [3:0] RATE_36 = 4'b1011;
    localparam logic [3:0] RATE_48 = 4'b0001;
    localparam logic [3:0] RATE_54 = 4'b0011;

    // Controller FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_PAD   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic              legal;
        logic [ADDR_W-1:0] n_cbps;
        logic [2:0]        n_bpsc;
    } rate_cfg_t;

    // RATE -> modulation parameters; illegal codes return legal=0
    function automatic rate_cfg_t decode_rate(input logic [3:0] rate);
        rate_cfg_t cfg;
        cfg = '0;
        case (rate)
            RATE_6,  RATE_9:  begin cfg.legal = 1'b1; cfg.n_cbps = 9'd48;  cfg.n_bpsc = 3'd1; end
            RATE_12, RATE_18: begin cfg.legal = 1'b1; cfg.n_cbps = 9'd96;  cfg.n_bpsc = 3'd2; end
            RATE_24, RATE_36: begin cfg.legal = 1'b1; cfg.n_cbps = 9'd192; cfg.n_bpsc = 3'd4; end
            RATE_48, RATE_54: begin cfg.legal = 1'b1; cfg.n_cbps = 9'd288; cfg.n_bpsc = 3'd6; end
            default:          cfg = '0;
        endcase
        return cfg;
    endfunction

    // s = max(N_BPSC/2, 1)
    function automatic logic [1:0] s_of_bpsc(input logic [2:0] n_bpsc);
        logic [1:0] s;
        case (n_bpsc)
            3'd4:    s = 2'd2;
            3'd6:    s = 2'd3;
            default: s = 2'd1;
        endcase
        return s;
    endfunction

    // v mod 3 for a 4-bit value without a divider: 4 == 1 (mod 3), so fold the two bit pairs
    function automatic logic [1:0] mod3_4b(input logic [3:0] v);
        logic [2:0] t;
        t = {1'b0, v[3:2]} + {1'b0, v[1:0]};
        if (t >= 3'd6)
            t = t - 3'd6;
        else if (t >= 3'd3)
            t = t - 3'd3;
        return t[1:0];
    endfunction

endpackage

// File: rtl/interleaver_ctrl_addr_gen.sv
// Permuted write-address generator: tracks k as {row, col}, accumulates
// i = row + col*N/16 and i mod 3, and forms j(k) for s = 1, 2 or 3.
module interleaver_addr_gen
    import interleaver_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              inc,
    input  logic [ADDR_W-1:0] n_cbps,
    input  logic [1:0]        s_sel,
    output logic              k_last,
    output logic [ADDR_W-1:0] j
);

    logic [3:0]        col;
    logic [4:0]        row;
    logic [ADDR_W-1:0] i_acc;
    logic [1:0]        i_mod3;
    logic [4:0]        step;
    logic [1:0]        col_m3;
    logic [2:0]        t3;

    // N/16 column stride (3, 6, 12 or 18)
    assign step   = n_cbps[ADDR_W-1:4];
    assign k_last = ({row, col} == (n_cbps - 9'd1));

    // k counter and i accumulator; every legal stride is a multiple of 3,
    // so i mod 3 only moves when a new row starts
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col    <= '0;
            row    <= '0;
            i_acc  <= '0;
            i_mod3 <= '0;
        end else if (clear) begin
            col    <= '0;
            row    <= '0;
            i_acc  <= '0;
            i_mod3 <= '0;
        end else if (inc) begin
            if (col == 4'd15) begin
                col    <= '0;
                row    <= row + 5'd1;
                i_acc  <= ADDR_W'(row) + ADDR_W'(1);
                i_mod3 <= (i_mod3 == 2'd2) ? 2'd0 : i_mod3 + 2'd1;
            end else begin
                col   <= col + 4'd1;
                i_acc <= i_acc + ADDR_W'(step);
            end
        end
    end

    // j = s*floor(i/s) + (i + N - col) mod s; for s=3, N=288 is a multiple of 3
    always_comb begin
        col_m3 = mod3_4b(col);
        t3     = {1'b0, i_mod3} + 3'd3 - {1'b0, col_m3};
        if (t3 >= 3'd3)
            t3 = t3 - 3'd3;
        case (s_sel)
            2'd2:    j = {i_acc[ADDR_W-1:1], i_acc[0] ^ col[0]};
            2'd3:    j = (i_acc - ADDR_W'(i_mod3)) + ADDR_W'(t3[1:0]);
            default: j = i_acc;
        endcase
    end

endmodule

// File: rtl/interleaver_ctrl.sv
// 802.11a block interleaver controller: decodes RATE, writes coded bits at
// permuted addresses into two ping-pong 1-bit RAM banks, pads the last
// symbol with zeros, and streams each full bank out in address order.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and once raised holds its data.
module interleaver_ctrl
    import interleaver_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [3:0]        rate,
    input  logic              start,
    output logic              rate_err,
    input  logic              in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] n_cbps,
    output logic              busy,
    output logic [1:0]        fsm_state
);

    logic [1:0]        state, state_nx;
    logic [1:0]        full, full_nx;
    logic [1:0]        s_sel;
    rate_cfg_t         cfg;
    logic              start_ok, start_bad;
    logic              wr_fill, wr_pad, sym_done, rd_done;
    logic              k_last, gen_clear, gen_inc;
    logic [ADDR_W-1:0] j_addr;

    assign cfg       = decode_rate(rate);
    assign start_ok  = start & (state == ST_IDLE) & cfg.legal;
    assign start_bad = start & (state == ST_IDLE) & ~cfg.legal;

    // Write side: a bit lands in RAM in the same cycle it is accepted
    assign in_ready  = (state == ST_FILL) & ~full[wr_bank];
    assign wr_fill   = in_valid & in_ready;
    assign wr_pad    = (state == ST_PAD) & ~full[wr_bank];
    assign wr_en     = wr_fill | wr_pad;
    assign wr_data   = wr_fill & in_data;
    assign wr_addr   = j_addr;
    assign sym_done  = wr_en & k_last;

    // Read side: issue a read whenever the output register is free or draining
    assign rd_en     = full[rd_bank] & (~out_valid | out_ready);
    assign rd_done   = rd_en & (rd_addr == (n_cbps - 9'd1));

    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    assign gen_clear = start_ok | sym_done;
    assign gen_inc   = wr_en & ~k_last;

    interleaver_addr_gen u_addr_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (gen_clear),
        .inc     (gen_inc),
        .n_cbps  (n_cbps),
        .s_sel   (s_sel),
        .k_last  (k_last),
        .j       (j_addr)
    );

    // Frame sequencing: fill, optional zero padding, then wait for the banks to empty
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nx = ST_FILL;
            ST_FILL:  if (wr_fill && in_last) state_nx = k_last ? ST_DRAIN : ST_PAD;
            ST_PAD:   if (wr_pad && k_last) state_nx = ST_DRAIN;
            ST_DRAIN: if ((full == 2'b00) && !out_valid) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Bank-full flags; a set and a clear in one cycle always hit different banks
    always_comb begin
        full_nx = full;
        if (sym_done)
            full_nx[wr_bank] = 1'b1;
        if (rd_done)
            full_nx[rd_bank] = 1'b0;
    end

    // State, frame configuration and RATE error pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            n_cbps   <= '0;
            s_sel    <= '0;
            rate_err <= 1'b0;
        end else begin
            state    <= state_nx;
            rate_err <= start_bad;
            if (start_ok) begin
                n_cbps <= cfg.n_cbps;
                s_sel  <= s_of_bpsc(cfg.n_bpsc);
            end
        end
    end

    // Bank pointers, read address and output-valid register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
        end else begin
            full <= full_nx;
            if (sym_done)
                wr_bank <= ~wr_bank;
            if (rd_en) begin
                if (rd_done) begin
                    rd_addr <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_addr <= rd_addr + 9'd1;
                end
            end
            if (rd_en)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule
